// File: rtl/counter_cmd_sequencer_if.sv
// rtl/counter_cmd_sequencer_if.sv - command channel between requester and counter sequencer
//  cmd_valid  requester -> sequencer  command present
//  cmd_ready  sequencer -> requester  sequencer idle, command will be taken this edge
//  cmd_op     requester -> sequencer  00 LOAD, 01 UP, 10 DOWN, 11 HOLD
//  cmd_arg    requester -> sequencer  LOAD value or cycle count
//  abort      requester -> sequencer  cut the running command short
interface counter_cmd_sequencer_if #(
    parameter int ARG_WIDTH = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [ARG_WIDTH-1:0] cmd_arg;
    logic                 abort;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        output abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        input  abort,
        output cmd_ready
    );
endinterface

// File: rtl/counter_cmd_sequencer.sv
// rtl/counter_cmd_sequencer.sv - command-driven sequencer for the up/down counter control pins
//  clk        clock, all state on posedge
//  rst_       asynchronous active-low reset
//  cmd        command channel (slave side): valid/ready/op/arg/abort
//  ld_cnt_    counter load, active low (registered)
//  updn_cnt   1 = count up, 0 = count down (registered)
//  count_enb  counter enable (registered)
//  data_in    load value to counter (registered)
//  busy       command in progress
//  done       one-cycle pulse when a command retires
//  aborted    qualifies done: command was cut short
module counter_cmd_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_,
    counter_cmd_sequencer_if.slave cmd,
    output logic                   ld_cnt_,
    output logic                   updn_cnt,
    output logic                   count_enb,
    output logic [DATA_WIDTH-1:0]  data_in,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_HOLD = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic                  ld_n_q, ld_n_d;
    logic                  updn_q, updn_d;
    logic                  enb_q, enb_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  abrt_q, abrt_d;

    logic [DATA_WIDTH-1:0] arg_val;
    logic [CNT_WIDTH-1:0]  arg_cnt;

    assign arg_val = cmd.cmd_arg[DATA_WIDTH-1:0];
    assign arg_cnt = cmd.cmd_arg[CNT_WIDTH-1:0];

    // Drive outputs default to the idle values every cycle; only LOAD/RUN override them,
    // so leaving RUN (normally or by abort) idles the counter pins on the same edge.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ld_n_d  = 1'b1;
        updn_d  = 1'b0;
        enb_d   = 1'b0;
        data_d  = '0;
        done_d  = 1'b0;
        abrt_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    if (cmd.cmd_op == OP_LOAD) begin
                        state_d = S_LOAD;
                        ld_n_d  = 1'b0;
                        data_d  = arg_val;
                    end else if (arg_cnt == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        rem_d   = arg_cnt;
                        enb_d   = (cmd.cmd_op != OP_HOLD);
                        updn_d  = (cmd.cmd_op == OP_UP);
                    end
                end
            end
            S_LOAD: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_RUN: begin
                // Last drive cycle wins over abort: an abort here would change nothing.
                if (rem_q == CNT_ONE) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    rem_d   = '0;
                end else if (cmd.abort) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    abrt_d  = 1'b1;
                    rem_d   = '0;
                end else begin
                    rem_d   = rem_q - CNT_ONE;
                    enb_d   = enb_q;
                    updn_d  = updn_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            ld_n_q  <= 1'b1;
            updn_q  <= 1'b0;
            enb_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ld_n_q  <= ld_n_d;
            updn_q  <= updn_d;
            enb_q   <= enb_d;
            data_q  <= data_d;
            done_q  <= done_d;
            abrt_q  <= abrt_d;
        end
    end

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign ld_cnt_       = ld_n_q;
    assign updn_cnt      = updn_q;
    assign count_enb     = enb_q;
    assign data_in       = data_q;
    assign done          = done_q;
    assign aborted       = abrt_q;
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb/tb_counter_cmd_sequencer.sv - self-checking bench for counter_cmd_sequencer
module tb_counter_cmd_sequencer;
    logic       clk;
    logic       rst_;
    logic       ld_cnt_;
    logic       updn_cnt;
    logic       count_enb;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic       aborted;

    int checks = 0;
    int errors = 0;

    counter_cmd_sequencer_if #(.ARG_WIDTH(8)) ifc ();

    counter_cmd_sequencer #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .cmd       (ifc.slave),
        .ld_cnt_   (ld_cnt_),
        .updn_cnt  (updn_cnt),
        .count_enb (count_enb),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ld_n;
        logic       updn;
        logic       enb;
        logic [7:0] data;
        logic       busy;
        logic       ready;
        logic       done;
        logic       ab;
    } exp_t;

    exp_t       expq[$];
    logic       prev_ready = 1'b1;
    int         plan_abort = 0;
    int         n_acc = 0;
    int         done_seen = 0;
    int         abort_seen = 0;
    logic [7:0] cnt = 8'h00;

    function automatic exp_t mk(logic ld_n, logic updn, logic enb, logic [7:0] data,
                                logic dn, logic ab);
        exp_t s;
        s.ld_n = ld_n; s.updn = updn; s.enb = enb; s.data = data;
        s.busy = 1'b1; s.ready = 1'b0; s.done = dn; s.ab = ab;
        return s;
    endfunction

    function automatic exp_t idle_e();
        exp_t s;
        s = '0;
        s.ld_n = 1'b1;
        s.ready = 1'b1;
        return s;
    endfunction

    // Expected per-cycle outputs of a whole command, from its op, arg and planned abort cycle.
    function automatic void build(logic [1:0] op, logic [7:0] arg, int k);
        int nd;
        if (op == 2'b00) begin
            expq.push_back(mk(1'b0, 1'b0, 1'b0, arg, 1'b0, 1'b0));
            expq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0));
        end else begin
            nd = (k > 0 && k < int'(arg)) ? k : int'(arg);
            for (int i = 0; i < nd; i++)
                expq.push_back(mk(1'b1, op == 2'b01, op != 2'b11, 8'h00, 1'b0, 1'b0));
            expq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, nd < int'(arg)));
        end
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Model + per-cycle compare
    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(posedge clk);
            if (!ld_cnt_)      cnt = data_in;
            else if (count_enb) cnt = updn_cnt ? cnt + 8'd1 : cnt - 8'd1;
            if (!rst_) begin
                expq.delete();
                e = idle_e();
            end else begin
                if (prev_ready && ifc.cmd_valid) begin
                    build(ifc.cmd_op, ifc.cmd_arg, plan_abort);
                    n_acc++;
                end
                e = (expq.size() > 0) ? expq.pop_front() : idle_e();
            end
            #1;
            g = {ld_cnt_, updn_cnt, count_enb, data_in, busy, ifc.cmd_ready, done, aborted};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cycle_outputs @%0t: got %h expected %h", $time, g, e);
            end
            if (done) done_seen++;
            if (done && aborted) abort_seen++;
            prev_ready = e.ready;
        end
    end

    // k>0: raise abort in RUN cycle k; k<0: abort high alongside cmd_valid in IDLE
    task automatic issue(logic [1:0] op, logic [7:0] arg, int k);
        int acc0;
        bit got;
        @(negedge clk);
        ifc.cmd_op = op;
        ifc.cmd_arg = arg;
        ifc.cmd_valid = 1'b1;
        plan_abort = k;
        if (k < 0) ifc.abort = 1'b1;
        acc0 = n_acc;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #2;
            if (n_acc != acc0) got = 1'b1;
        end
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        ifc.abort = 1'b0;
        plan_abort = 0;
        if (k > 0) begin
            repeat (k - 1) @(negedge clk);
            ifc.abort = 1'b1;
            @(negedge clk);
            ifc.abort = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (expq.size() != 0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (i >= 300) begin
            errors++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
        @(negedge clk);
    endtask

    initial begin
        rst_ = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op = 2'b00;
        ifc.cmd_arg = 8'h00;
        ifc.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, ifc.cmd_ready}, 32'd1);
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        chk("reset_drive", {ld_cnt_, count_enb, updn_cnt, data_in, done, aborted},
            {1'b1, 12'h000});
        @(negedge clk);
        rst_ = 1'b1;

        issue(2'b00, 8'hA5, 0);
        wait_idle();
        chk("load_a5_cnt", {24'd0, cnt}, 32'h0000_00A5);

        issue(2'b00, 8'hFE, 0);
        issue(2'b01, 8'd3, 0);
        wait_idle();
        chk("up3_from_fe_cnt", {24'd0, cnt}, 32'h0000_0001);

        issue(2'b10, 8'd0, 0);
        issue(2'b11, 8'd2, 0);
        wait_idle();
        chk("down0_hold2_cnt", {24'd0, cnt}, 32'h0000_0001);

        issue(2'b01, 8'd5, 2);
        wait_idle();
        chk("up5_abort2_cnt", {24'd0, cnt}, 32'h0000_0003);
        issue(2'b01, 8'd5, 5);
        wait_idle();
        chk("up5_abort_last_cnt", {24'd0, cnt}, 32'h0000_0008);

        issue(2'b10, 8'd1, -1);
        wait_idle();
        chk("idle_abort_down1_cnt", {24'd0, cnt}, 32'h0000_0007);
        issue(2'b00, 8'h10, 1);
        wait_idle();
        chk("load_abort_cnt", {24'd0, cnt}, 32'h0000_0010);

        issue(2'b01, 8'd4, 0);
        issue(2'b10, 8'd2, 0);
        wait_idle();
        chk("held_valid_cnt", {24'd0, cnt}, 32'h0000_0012);

        issue(2'b01, 8'd10, 0);
        repeat (3) @(negedge clk);
        #2;
        rst_ = 1'b0;
        #1;
        chk("async_reset_drive", {ld_cnt_, count_enb, updn_cnt, data_in, done, aborted},
            {1'b1, 12'h000});
        chk("async_reset_ready", {30'd0, ifc.cmd_ready, busy}, 32'd2);
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_ready", {30'd0, ifc.cmd_ready, busy}, 32'd2);

        chk("done_pulses", done_seen, 32'd11);
        chk("aborted_pulses", abort_seen, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
